// File: rtl/aes_io_pkg.sv
// Shared widths and FSM encoding for the AES byte-to-word input port.
package aes_io_pkg;

  localparam int BYTE_W          = 8;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int BYTES_PER_FRAME = 16;
  localparam int WORDS_PER_FRAME = 4;
  localparam int CNT_W           = $clog2(BYTES_PER_FRAME);
  localparam int WIDX_W          = $clog2(WORDS_PER_FRAME);

  typedef enum logic {
    RECV = 1'b0,
    PASS = 1'b1
  } state_e;

endpackage

// File: rtl/aes_strobe_edge.sv
// Rising-edge detector for the byte strobe; prev resets high so a strobe held across reset is not a byte.
module aes_strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic strobe_i,
  output logic pulse_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b1;
    else      prev_q <= strobe_i;
  end

  assign pulse_o = strobe_i & ~prev_q;

endmodule

// File: rtl/aes_inport.sv
// Collects 16 strobed bytes into a 128-bit block and streams it to the AES core as four 32-bit words.
// Handshake: a byte is taken on the cycle in_valid rises while in_ready=1; aes_en marks each valid pass_data word.
module aes_inport
  import aes_io_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16'd65535,
  parameter int          TO_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic [WORD_W-1:0] pass_data,
  output logic              aes_en,
  output logic              in_ready,
  output logic              in_err,
  output logic              dbg_state
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [WIDX_W-1:0]   widx_q, widx_d, widx_nxt;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [BLOCK_W-1:0]  frame_q, frame_d;
  logic [WORD_W-1:0]   pass_q, pass_d;
  logic                err_q, err_d;
  logic                byte_pulse, capture, last_byte, last_word, timeout_hit;

  aes_strobe_edge u_edge (
    .clk      (clk),
    .rst      (rst),
    .strobe_i (in_valid),
    .pulse_o  (byte_pulse)
  );

  assign capture     = (state_q == RECV) && byte_pulse;
  assign last_byte   = capture && (byte_cnt_q == CNT_W'(BYTES_PER_FRAME - 1));
  assign last_word   = (widx_q == WIDX_W'(WORDS_PER_FRAME - 1));
  assign timeout_hit = (state_q == RECV) && !capture && (byte_cnt_q != '0) &&
                       (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign widx_nxt    = widx_q + 1'b1;

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RECV;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RECV:    if (last_byte) state_d = PASS;
      PASS:    if (last_word) state_d = RECV;
      default: state_d = RECV;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == RECV);
    aes_en    = (state_q == PASS);
    dbg_state = state_q;
    pass_data = pass_q;
    in_err    = err_q;
  end

  // Byte k lands at bit (15-k)*8, i.e. the first byte is the most significant.
  always_comb begin
    frame_d    = frame_q;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = '0;
    err_d      = timeout_hit;
    if (capture) begin
      frame_d[{~byte_cnt_q, 3'b000} +: BYTE_W] = in_data;
      byte_cnt_d = byte_cnt_q + 1'b1;
    end else if (timeout_hit) begin
      byte_cnt_d = '0;
    end else if ((state_q == RECV) && (byte_cnt_q != '0)) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Word 0 is loaded on the capture edge so it is presented the very next cycle.
  always_comb begin
    widx_d = widx_q;
    pass_d = pass_q;
    if (last_byte) begin
      widx_d = '0;
      pass_d = frame_d[BLOCK_W-1 -: WORD_W];
    end else if ((state_q == PASS) && !last_word) begin
      widx_d = widx_nxt;
      pass_d = frame_q[{~widx_nxt, 5'b00000} +: WORD_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_q <= '0;
      widx_q     <= '0;
      to_cnt_q   <= '0;
      frame_q    <= '0;
      pass_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      widx_q     <= widx_d;
      to_cnt_q   <= to_cnt_d;
      frame_q    <= frame_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_aes_inport.sv
// Bench for aes_inport: directed scenarios plus random byte streams against a frame-level model.
module tb_aes_inport;

  localparam int TO = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic [31:0] pass_data, pass_data_l;
  logic        aes_en, in_ready, in_err, dbg_state;
  logic        aes_en_l, in_ready_l, in_err_l, dbg_state_l;

  aes_inport #(.TIMEOUT(TO), .TO_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .pass_data(pass_data), .aes_en(aes_en), .in_ready(in_ready),
    .in_err(in_err), .dbg_state(dbg_state)
  );

  aes_inport #(.TIMEOUT(16'd65535), .TO_W(16)) u_dut_long (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .pass_data(pass_data_l), .aes_en(aes_en_l), .in_ready(in_ready_l),
    .in_err(in_err_l), .dbg_state(dbg_state_l)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // behavioural model: bytes into a 16-entry frame, completed frames become 4 words
  bit          m_prev = 1'b1;
  bit          m_edge;
  int          m_cnt = 0;
  int          m_idle = 0;
  logic [7:0]  m_frame [16];
  logic [31:0] exp_q [$];
  logic [31:0] e_data = 32'h0;
  bit          e_en = 1'b0;
  bit          e_err = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_prev = 1'b1; m_cnt = 0; m_idle = 0;
      for (int i = 0; i < 16; i++) m_frame[i] = 8'h00;
      exp_q.delete();
      e_data = 32'h0; e_en = 1'b0; e_err = 1'b0;
    end else begin
      m_edge = in_valid && !m_prev;
      m_prev = in_valid;
      e_err  = 1'b0;
      if (e_en) begin
        if (exp_q.size() > 0) e_data = exp_q.pop_front();
        else e_en = 1'b0;
      end else if (m_edge) begin
        m_frame[m_cnt] = in_data;
        m_cnt++;
        m_idle = 0;
        if (m_cnt == 16) begin
          m_cnt = 0;
          for (int w = 0; w < 4; w++)
            exp_q.push_back({m_frame[4*w], m_frame[4*w+1], m_frame[4*w+2], m_frame[4*w+3]});
          e_data = exp_q.pop_front();
          e_en = 1'b1;
        end
      end else if (m_cnt != 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_cnt = 0; m_idle = 0; e_err = 1'b1;
        end
      end
    end
  end

  // scoreboard compare plus burst / error monitors
  logic [31:0] obs_q [$];
  logic [31:0] obs_l_q [$];
  int first_en_cyc = -1;
  int err_cyc = -1;
  int err_count = 0;

  always @(negedge clk) begin
    if (aes_en === 1'b1) begin
      obs_q.push_back(pass_data);
      if (first_en_cyc < 0) first_en_cyc = cyc;
    end
    if (in_err === 1'b1) begin
      err_count++;
      err_cyc = cyc;
    end
    if (aes_en_l === 1'b1) obs_l_q.push_back(pass_data_l);
    if (chk_en) begin
      check("aes_en", aes_en, e_en);
      check("in_ready", in_ready, !e_en);
      check("in_err", in_err, e_err);
      check("pass_data", pass_data, e_data);
      check("dbg_state", dbg_state, e_en);
    end
  end

  // driver tasks
  task automatic cyc1();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] d, input int hold, input int gap);
    in_data = d;
    in_valid = 1'b1;
    repeat (hold) cyc1();
    in_valid = 1'b0;
    repeat (gap) cyc1();
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_l_q.delete();
    first_en_cyc = -1;
    err_cyc = -1;
    err_count = 0;
  endtask

  task automatic check_frame(input string name, input logic [7:0] base, input int start, input bit long_dut);
    logic [31:0] w;
    logic [7:0]  b;
    for (int i = 0; i < 4; i++) begin
      b = base + 8'(4 * i);
      w = {b, b + 8'd1, b + 8'd2, b + 8'd3};
      if (long_dut) check(name, (obs_l_q.size() > start + i) ? obs_l_q[start+i] : 32'hxxxxxxxx, w);
      else          check(name, (obs_q.size() > start + i) ? obs_q[start+i] : 32'hxxxxxxxx, w);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cap;
    bit got;

    repeat (3) cyc1();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_aes_en", aes_en, 1'b0);
    check("rst_pass_data", pass_data, 32'h0);
    check("rst_in_err", in_err, 1'b0);
    rst = 1'b1;
    chk_en = 1'b1;
    cyc1();

    // bytes 00..0F, one strobe every 8 cycles
    clear_obs();
    cap = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) cap = cyc + 1;
      send_byte(8'(i), 1, 7);
    end
    repeat (6) cyc1();
    check("basic_burst_len", obs_q.size(), 4);
    check("basic_latency", first_en_cyc, cap);
    check("basic_w0", (obs_q.size() > 0) ? obs_q[0] : 32'hx, 32'h00010203);
    check("basic_w1", (obs_q.size() > 1) ? obs_q[1] : 32'hx, 32'h04050607);
    check("basic_w2", (obs_q.size() > 2) ? obs_q[2] : 32'hx, 32'h08090A0B);
    check("basic_w3", (obs_q.size() > 3) ? obs_q[3] : 32'hx, 32'h0C0D0E0F);

    // partial frame of 5 bytes times out, then a clean AA.. frame
    clear_obs();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) cap = cyc + 1;
      send_byte(8'(8'h90 + i), 1, 1);
    end
    repeat (14) cyc1();
    check("timeout_err_count", err_count, 1);
    check("timeout_err_cycle", err_cyc, cap + TO);
    clear_obs();
    for (int i = 0; i < 16; i++) send_byte(8'(8'hAA + i), 1, 1);
    repeat (6) cyc1();
    check("after_to_len", obs_q.size(), 4);
    check("after_to_w0", (obs_q.size() > 0) ? obs_q[0] : 32'hx, 32'hAAABACAD);
    check("after_to_w3", (obs_q.size() > 3) ? obs_q[3] : 32'hx, 32'hB6B7B8B9);
    check_frame("after_to_frame", 8'hAA, 0, 1'b0);

    // strobes during PASS are dropped
    clear_obs();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1, 1);
    send_byte(8'hEE, 1, 1);
    send_byte(8'hEE, 1, 1);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i), 1, 1);
    repeat (6) cyc1();
    check("pass_ignore_len", obs_q.size(), 8);
    check_frame("pass_ignore_first", 8'h20, 0, 1'b0);
    check_frame("pass_ignore_second", 8'h30, 4, 1'b0);

    // reset in the middle of a burst, with in_valid held high across release
    clear_obs();
    for (int i = 0; i < 15; i++) send_byte(8'(8'h40 + i), 1, 1);
    in_data = 8'h4F;
    in_valid = 1'b1;
    cyc1();
    in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      cyc1();
      got = (obs_q.size() >= 2);
    end
    check("mid_rst_wait", got, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_aes_en", aes_en, 1'b0);
    check("mid_rst_pass_data", pass_data, 32'h0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_in_err", in_err, 1'b0);
    check("mid_rst_long_en", aes_en_l, 1'b0);
    in_valid = 1'b1;
    cyc1();
    cyc1();
    rst = 1'b1;
    repeat (3) cyc1();
    in_valid = 1'b0;
    cyc1();
    clear_obs();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h50 + i), 1, 1);
    repeat (6) cyc1();
    check("post_rst_len", obs_q.size(), 4);
    check_frame("post_rst_frame", 8'h50, 0, 1'b0);

    // every byte lands exactly on the timeout cycle
    clear_obs();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h60 + i), 1, 9);
    repeat (6) cyc1();
    check("coincide_no_err", err_count, 0);
    check("coincide_len", obs_q.size(), 4);
    check_frame("coincide_frame", 8'h60, 0, 1'b0);

    // in_valid held 20 cycles per byte; long-timeout instance must see one frame
    rst = 1'b0;
    cyc1();
    rst = 1'b1;
    cyc1();
    clear_obs();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h70 + i), 20, 2);
    repeat (6) cyc1();
    check("held_long_len", obs_l_q.size(), 4);
    check_frame("held_long_frame", 8'h70, 0, 1'b1);
    check("held_short_errs", err_count, 16);
    check("held_short_len", obs_q.size(), 0);

    // random byte streams with occasional long idles
    for (int k = 0; k < 400; k++) begin
      int hold, gap;
      hold = $urandom_range(1, 3);
      gap = ($urandom_range(0, 19) == 0) ? $urandom_range(10, 14) : $urandom_range(0, 9);
      send_byte(8'($urandom_range(0, 255)), hold, gap);
    end
    repeat (8) cyc1();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
